// File: rtl/regfile_mp.sv
// Multi-port register file: WR_DEPTH write ports, RD_DEPTH registered read ports.
// Write conflicts on one address resolve to the highest-index port. Writes to
// out-of-range addresses, or to register 0 when ZERO_REG=1, are dropped.
// Optional macro REGFILE_BYPASS_EN selects write-first reads (a read returns
// data written on the same edge); when undefined, reads are read-first.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_DEPTH   = 2,
    parameter int WR_DEPTH   = 2,
    parameter int REG_DEPTH  = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_n,
    input  logic [WR_DEPTH-1:0]            wr,
    input  logic [ADDR_WIDTH*WR_DEPTH-1:0] rw,
    input  logic [DATA_WIDTH*WR_DEPTH-1:0] d,
    input  logic [RD_DEPTH-1:0]            re,
    input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
    output logic [DATA_WIDTH*RD_DEPTH-1:0] q,
    output logic [RD_DEPTH-1:0]            q_valid
);

    // One extra bit so the depth compares cleanly when REG_DEPTH == 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(REG_DEPTH);

    logic [DATA_WIDTH-1:0]           r_mem [REG_DEPTH];
    logic [DATA_WIDTH*RD_DEPTH-1:0]  r_q;
    logic [RD_DEPTH-1:0]             r_q_valid;

    logic [ADDR_WIDTH-1:0]           w_waddr   [WR_DEPTH];
    logic [DATA_WIDTH-1:0]           w_wdata   [WR_DEPTH];
    logic [WR_DEPTH-1:0]             w_wr_ok;
    logic [ADDR_WIDTH-1:0]           w_raddr   [RD_DEPTH];
    logic [DATA_WIDTH-1:0]           w_rd_data [RD_DEPTH];

    // Unpack write ports and decide which writes are accepted this edge.
    always_comb begin
        for (int j = 0; j < WR_DEPTH; j++) begin
            w_waddr[j] = rw[ADDR_WIDTH*j +: ADDR_WIDTH];
            w_wdata[j] = d[DATA_WIDTH*j +: DATA_WIDTH];
            w_wr_ok[j] = ~en_n & wr[j]
                       & ({1'b0, w_waddr[j]} < LP_DEPTH)
                       & ~((ZERO_REG != 0) && (w_waddr[j] == '0));
        end
    end

    // Per-port read data: zero for out-of-range or hardwired-zero addresses.
    always_comb begin
        for (int i = 0; i < RD_DEPTH; i++) begin
            w_raddr[i]   = rr[ADDR_WIDTH*i +: ADDR_WIDTH];
            w_rd_data[i] = '0;
            if (({1'b0, w_raddr[i]} < LP_DEPTH) &&
                !((ZERO_REG != 0) && (w_raddr[i] == '0))) begin
                w_rd_data[i] = r_mem[w_raddr[i]];
            end
`ifdef REGFILE_BYPASS_EN
            // Ascending scan so the highest-index accepted write wins, matching storage.
            for (int j = 0; j < WR_DEPTH; j++) begin
                if (w_wr_ok[j] && (w_waddr[j] == w_raddr[i])) begin
                    w_rd_data[i] = w_wdata[j];
                end
            end
`endif
        end
    end

    // Storage update; later ports overwrite earlier ones on a shared address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else begin
            for (int j = 0; j < WR_DEPTH; j++) begin
                if (w_wr_ok[j]) begin
                    r_mem[w_waddr[j]] <= w_wdata[j];
                end
            end
        end
    end

    // Registered read ports; q holds when not read, q_valid flags a fresh load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_q_valid <= '0;
        end else if (en_n) begin
            r_q_valid <= '0;
        end else begin
            for (int i = 0; i < RD_DEPTH; i++) begin
                if (re[i]) begin
                    r_q[DATA_WIDTH*i +: DATA_WIDTH] <= w_rd_data[i];
                    r_q_valid[i]                    <= 1'b1;
                end else begin
                    r_q_valid[i]                    <= 1'b0;
                end
            end
        end
    end

    assign q       = r_q;
    assign q_valid = r_q_valid;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp with default parameters: directed cases followed by
// random traffic, compared against an array-based reference model.
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic        en_n;
    logic [1:0]  wr;
    logic [9:0]  rw;
    logic [63:0] d;
    logic [1:0]  re;
    logic [9:0]  rr;
    logic [63:0] q;
    logic [1:0]  q_valid;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_mem [32];
    logic [63:0] m_q;
    logic [1:0]  m_qv;

    regfile_mp dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_n    (en_n),
        .wr      (wr),
        .rw      (rw),
        .d       (d),
        .re      (re),
        .rr      (rr),
        .q       (q),
        .q_valid (q_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag);
        total++;
        assert (q === m_q) else begin
            bad++;
            $error("FAIL %s q observed=%h expected=%h", tag, q, m_q);
        end
        total++;
        assert (q_valid === m_qv) else begin
            bad++;
            $error("FAIL %s q_valid observed=%b expected=%b", tag, q_valid, m_qv);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 32; k++) m_mem[k] = '0;
        m_q  = '0;
        m_qv = '0;
    endtask

    // Drive one cycle of inputs, advance the model, clock, and compare.
    task automatic step(input logic en_n_i, input logic [1:0] wr_i, input logic [9:0] rw_i,
                        input logic [63:0] d_i, input logic [1:0] re_i, input logic [9:0] rr_i,
                        input string tag);
        logic [31:0] pre [32];
        logic [4:0]  a;
        en_n = en_n_i; wr = wr_i; rw = rw_i; d = d_i; re = re_i; rr = rr_i;
        pre = m_mem;
        if (!en_n_i) begin
            for (int j = 0; j < 2; j++) begin
                a = rw_i[5*j +: 5];
                if (wr_i[j] && a != 5'd0) m_mem[a] = d_i[32*j +: 32];
            end
            for (int i = 0; i < 2; i++) begin
                a = rr_i[5*i +: 5];
                if (re_i[i]) begin
`ifdef REGFILE_BYPASS_EN
                    m_q[32*i +: 32] = (a == 5'd0) ? 32'h0 : m_mem[a];
`else
                    m_q[32*i +: 32] = (a == 5'd0) ? 32'h0 : pre[a];
`endif
                    m_qv[i] = 1'b1;
                end else begin
                    m_qv[i] = 1'b0;
                end
            end
        end else begin
            m_qv = 2'b00;
        end
        @(posedge clk);
        #1;
        check(tag);
    endtask

    initial begin
        rst_n = 1'b0; en_n = 1'b1; wr = '0; rw = '0; d = '0; re = '0; rr = '0;
        model_clear();
        #12;
        check("reset");
        rst_n = 1'b1;

        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b11, {5'd31, 5'd5}, "rd_after_reset");

        step(1'b0, 2'b01, {5'd0, 5'd27}, {32'd0, 32'hdcaf484c}, 2'b00, 10'd0, "wr27");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b11, {5'd27, 5'd27}, "rd27_both");

        step(1'b0, 2'b11, {5'd4, 5'd4}, {32'h37373737, 32'h11111111}, 2'b00, 10'd0, "wr_conflict");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b11, {5'd4, 5'd4}, "rd_conflict");

        step(1'b0, 2'b01, {5'd0, 5'd0}, {32'd0, 32'hffffffff}, 2'b00, 10'd0, "wr_zero");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b01, {5'd0, 5'd0}, "rd_zero");

        step(1'b0, 2'b01, {5'd0, 5'd9}, {32'd0, 32'hA}, 2'b00, 10'd0, "wr9_A");
        step(1'b0, 2'b10, {5'd9, 5'd0}, {32'hB, 32'd0}, 2'b11, {5'd9, 5'd9}, "bypass9");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b01, {5'd0, 5'd9}, "rd9_after");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b00, {5'd9, 5'd9}, "hold_no_re");

        step(1'b0, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h0000_3333}, 2'b00, 10'd0, "wr3_old");
        step(1'b1, 2'b01, {5'd0, 5'd3}, {32'd0, 32'h5555_5555}, 2'b11, {5'd3, 5'd3}, "wr3_disabled");
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b11, {5'd3, 5'd3}, "rd3_old");

        // Reset asserted between edges must clear outputs without a clock.
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'b00, 10'd0, 64'd0, 2'b11, {5'd27, 5'd3}, "rd_after_async");

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 7) == 0),
                 2'($urandom_range(0, 3)),
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 {$urandom, $urandom},
                 2'($urandom_range(0, 3)),
                 {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                 "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
